spi_cmd_engine: RTL and testbench

- Framing and response stage directly downstream of spi_driver's init/command sequencer.
- Takes an SD command index and argument and builds the 48-bit SPI frame, including CRC7 and the end bit.
- Serialises the frame on MOSI, using the SCLK edge strobes generated by spi_driver.
- Hunts for and captures the card's R1 response, plus an optional 4 trailing bytes (R3/R7), and returns it to the sequencer.

---
 rtl/spi_cmd_engine_if.sv | 24 ++
 rtl/spi_cmd_engine.sv | 185 ++++++++++++++++++
 tb/tb_spi_cmd_engine.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_engine_if.sv
// Command/response handshake between the SD init sequencer and spi_cmd_engine.
// The sequencer owns the master side and the engine owns the slave side.
interface spi_cmd_engine_if #(
  parameter int RESP_WIDTH = 40
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [5:0]            cmd_index_i;
  logic [31:0]           cmd_arg_i;
  logic                  resp_long_i;
  logic [RESP_WIDTH-1:0] resp_o;
  logic                  resp_valid_o;
  logic                  timeout_o;

  modport slave (
    input  cmd_valid_i, cmd_index_i, cmd_arg_i, resp_long_i,
    output cmd_ready_o, resp_o, resp_valid_o, timeout_o
  );

  modport master (
    output cmd_valid_i, cmd_index_i, cmd_arg_i, resp_long_i,
    input  cmd_ready_o, resp_o, resp_valid_o, timeout_o
  );
endinterface

// File: rtl/spi_cmd_engine.sv
// Builds the 48-bit SD command frame with CRC7, shifts it out on MOSI using the
// driver's SCLK edge strobes, then hunts for and captures the R1 (or R3/R7) reply.
module spi_cmd_engine #(
  parameter int COMMAND_WIDTH   = 48,
  parameter int RESP_WAIT_BYTES = 8,
  parameter int RESP_WIDTH      = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk_posedge,
  input  logic sclk_negedge,
  input  logic miso_i,
  output logic mosi_o,
  output logic cs_n_o,
  spi_cmd_engine_if.slave bus
);

  localparam int WAIT_BITS = RESP_WAIT_BYTES * 8;
  localparam int BIT_W     = $clog2(COMMAND_WIDTH + 1);
  localparam int IDX_W     = $clog2(COMMAND_WIDTH);
  localparam int WAIT_W    = $clog2(WAIT_BITS + 1);
  localparam int RX_W      = $clog2(RESP_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, DONE} state_t;

  state_t                   r_state, w_state;
  logic [COMMAND_WIDTH-1:0] r_frame, w_frame;
  logic                     r_long, w_long;
  logic [BIT_W-1:0]         r_bitCnt, w_bitCnt;
  logic [WAIT_W-1:0]        r_waitCnt, w_waitCnt;
  logic [RX_W-1:0]          r_rxCnt, w_rxCnt;
  logic [RESP_WIDTH-1:0]    r_rx, w_rx;
  logic [RESP_WIDTH-1:0]    r_resp, w_resp;
  logic                     r_respValid, w_respValid;
  logic                     r_timeout, w_timeout;
  logic                     r_mosi, w_mosi;
  logic                     r_csN, w_csN;

  logic [39:0]              w_crcData;
  logic [COMMAND_WIDTH-1:0] w_newFrame;
  logic [IDX_W-1:0]         w_bitIdx;
  logic [RX_W-1:0]          w_lastRx;
  logic [RESP_WIDTH-1:0]    w_respFinal;

  // CRC7, polynomial x^7 + x^3 + 1, seed 0, MSB first.
  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0};
      if (fb) crc = crc ^ 7'h09;
    end
    return crc;
  endfunction

  assign w_crcData   = {2'b01, bus.cmd_index_i, bus.cmd_arg_i};
  assign w_newFrame  = {w_crcData, crc7(w_crcData), 1'b1};
  assign w_bitIdx    = IDX_W'(COMMAND_WIDTH - 1) - IDX_W'(r_bitCnt);
  assign w_lastRx    = r_long ? RX_W'(RESP_WIDTH - 1) : RX_W'(7);
  assign w_respFinal = r_long ? r_rx : {r_rx[7:0], {(RESP_WIDTH-8){1'b0}}};

  assign bus.cmd_ready_o  = (r_state == IDLE);
  assign bus.resp_o       = r_resp;
  assign bus.resp_valid_o = r_respValid;
  assign bus.timeout_o    = r_timeout;
  assign mosi_o           = r_mosi;
  assign cs_n_o           = r_csN;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_frame     <= '0;
      r_long      <= 1'b0;
      r_bitCnt    <= '0;
      r_waitCnt   <= '0;
      r_rxCnt     <= '0;
      r_rx        <= '0;
      r_resp      <= '0;
      r_respValid <= 1'b0;
      r_timeout   <= 1'b0;
      r_mosi      <= 1'b1;
      r_csN       <= 1'b1;
    end else begin
      r_state     <= w_state;
      r_frame     <= w_frame;
      r_long      <= w_long;
      r_bitCnt    <= w_bitCnt;
      r_waitCnt   <= w_waitCnt;
      r_rxCnt     <= w_rxCnt;
      r_rx        <= w_rx;
      r_resp      <= w_resp;
      r_respValid <= w_respValid;
      r_timeout   <= w_timeout;
      r_mosi      <= w_mosi;
      r_csN       <= w_csN;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_frame     = r_frame;
    w_long      = r_long;
    w_bitCnt    = r_bitCnt;
    w_waitCnt   = r_waitCnt;
    w_rxCnt     = r_rxCnt;
    w_rx        = r_rx;
    w_resp      = r_resp;
    w_respValid = 1'b0;
    w_timeout   = 1'b0;
    w_mosi      = r_mosi;
    w_csN       = r_csN;

    unique case (r_state)
      IDLE: begin
        w_mosi = 1'b1;
        w_csN  = 1'b1;
        if (bus.cmd_valid_i) begin
          w_frame   = w_newFrame;
          w_long    = bus.resp_long_i;
          w_mosi    = w_newFrame[COMMAND_WIDTH-1];
          w_csN     = 1'b0;
          w_bitCnt  = '0;
          w_waitCnt = '0;
          w_rxCnt   = '0;
          w_rx      = '0;
          w_state   = SEND;
        end
      end

      // Counting to COMMAND_WIDTH marks the last bit as sampled; the following
      // falling edge releases MOSI high and starts the response hunt.
      SEND: begin
        if (sclk_posedge && (r_bitCnt != BIT_W'(COMMAND_WIDTH))) begin
          w_bitCnt = r_bitCnt + 1'b1;
        end else if (sclk_negedge) begin
          if (r_bitCnt == BIT_W'(COMMAND_WIDTH)) begin
            w_mosi    = 1'b1;
            w_waitCnt = '0;
            w_state   = WAIT;
          end else begin
            w_mosi = r_frame[w_bitIdx];
          end
        end
      end

      WAIT: begin
        if (sclk_posedge) begin
          if (!miso_i) begin
            w_rx    = {r_rx[RESP_WIDTH-2:0], 1'b0};
            w_rxCnt = RX_W'(1);
            w_state = RECV;
          end else begin
            w_waitCnt = r_waitCnt + 1'b1;
            if (r_waitCnt == WAIT_W'(WAIT_BITS - 1)) begin
              w_timeout = 1'b1;
              w_csN     = 1'b1;
              w_mosi    = 1'b1;
              w_state   = IDLE;
            end
          end
        end
      end

      RECV: begin
        if (sclk_posedge) begin
          w_rx    = {r_rx[RESP_WIDTH-2:0], miso_i};
          w_rxCnt = r_rxCnt + 1'b1;
          if (r_rxCnt == w_lastRx) w_state = DONE;
        end
      end

      DONE: begin
        w_resp      = w_respFinal;
        w_respValid = 1'b1;
        w_csN       = 1'b1;
        w_state     = IDLE;
      end

      default: w_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_cmd_engine.sv
// Directed bench for spi_cmd_engine: plays the spi_driver strobes and an SD card
// on MISO, checking frames, responses, timeout, busy handshake and mid-frame reset.
module tb_spi_cmd_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sclk_posedge = 1'b0;
  logic sclk_negedge = 1'b0;
  logic miso_i = 1'b1;
  logic mosi_o;
  logic cs_n_o;

  int compared     = 0;
  int mismatched   = 0;
  int validCount   = 0;
  int timeoutCount = 0;
  int acceptCount  = 0;
  int csErrCount   = 0;
  int gapClk       = 0;
  logic prevReady  = 1'b1;

  always #5 clk = ~clk;

  spi_cmd_engine_if #(.RESP_WIDTH(40)) cmdBus();

  spi_cmd_engine #(
    .COMMAND_WIDTH(48),
    .RESP_WAIT_BYTES(8),
    .RESP_WIDTH(40)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sclk_posedge(sclk_posedge),
    .sclk_negedge(sclk_negedge),
    .miso_i(miso_i),
    .mosi_o(mosi_o),
    .cs_n_o(cs_n_o),
    .bus(cmdBus)
  );

  // Output pulses and accepts are tallied from DUT outputs only; chip select must track busy.
  always @(negedge clk) begin
    if (cmdBus.resp_valid_o) validCount++;
    if (cmdBus.timeout_o) timeoutCount++;
    if (prevReady && !cmdBus.cmd_ready_o) acceptCount++;
    if (cs_n_o !== cmdBus.cmd_ready_o) csErrCount++;
    prevReady = cmdBus.cmd_ready_o;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 5000000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One SCLK period; MISO is set up before the rising strobe, MOSI sampled as the card would see it.
  task automatic sclkCycle(input logic misoBit, output logic mosiBit);
    miso_i       = misoBit;
    sclk_posedge = 1'b1;
    mosiBit      = mosi_o;
    @(negedge clk);
    sclk_posedge = 1'b0;
    repeat (gapClk) @(negedge clk);
    sclk_negedge = 1'b1;
    @(negedge clk);
    sclk_negedge = 1'b0;
    repeat (gapClk) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] arg, input logic lng, input bit hold);
    int n = 0;
    cmdBus.cmd_index_i = idx;
    cmdBus.cmd_arg_i   = arg;
    cmdBus.resp_long_i = lng;
    cmdBus.cmd_valid_i = 1'b1;
    while (!cmdBus.cmd_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("readyBeforeAccept", 64'(cmdBus.cmd_ready_o), 64'(1));
    @(negedge clk);
    if (!hold) cmdBus.cmd_valid_i = 1'b0;
  endtask

  task automatic sendFrame(output logic [47:0] frame);
    logic b;
    for (int i = 47; i >= 0; i--) begin
      sclkCycle(1'b1, b);
      frame[i] = b;
    end
  endtask

  task automatic cardReply(input int highBits, input logic [39:0] resp, input int nBits);
    logic b;
    for (int i = 0; i < highBits; i++) sclkCycle(1'b1, b);
    for (int i = 0; i < nBits; i++) sclkCycle(resp[39-i], b);
  endtask

  initial begin
    logic [47:0] f;
    logic b;
    int vb, tb, ab;

    cmdBus.cmd_valid_i = 1'b0;
    cmdBus.cmd_index_i = 6'd0;
    cmdBus.cmd_arg_i   = 32'd0;
    cmdBus.resp_long_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstReady", 64'(cmdBus.cmd_ready_o), 64'(1));
    checkOutput("rstMosi", 64'(mosi_o), 64'(1));
    checkOutput("rstCsN", 64'(cs_n_o), 64'(1));
    checkOutput("rstResp", 64'(cmdBus.resp_o), 64'(0));
    checkOutput("rstValid", 64'(cmdBus.resp_valid_o), 64'(0));
    checkOutput("rstTimeout", 64'(cmdBus.timeout_o), 64'(0));
    rst = 1'b1;
    @(negedge clk);

    // CMD0, two idle bytes before R1 = 0x01
    vb = validCount; tb = timeoutCount;
    applyStimulus(6'd0, 32'h0, 1'b0, 1'b0);
    checkOutput("cmd0CsLow", 64'(cs_n_o), 64'(0));
    checkOutput("cmd0Busy", 64'(cmdBus.cmd_ready_o), 64'(0));
    sendFrame(f);
    checkOutput("cmd0Frame", 64'(f), 64'h40_0000_0000_95);
    checkOutput("cmd0MosiIdle", 64'(mosi_o), 64'(1));
    cardReply(16, {8'h01, 32'h0}, 7);
    checkOutput("cmd0CsBeforeDone", 64'(cs_n_o), 64'(0));
    cardReply(0, 40'h80_0000_0000, 1);
    repeat (2) @(negedge clk);
    checkOutput("cmd0R1", 64'(cmdBus.resp_o[39:32]), 64'h01);
    checkOutput("cmd0Resp", 64'(cmdBus.resp_o), 64'h01_0000_0000);
    checkOutput("cmd0ValidPulses", 64'(validCount - vb), 64'(1));
    checkOutput("cmd0NoTimeout", 64'(timeoutCount - tb), 64'(0));
    checkOutput("cmd0ReadyBack", 64'(cmdBus.cmd_ready_o), 64'(1));
    checkOutput("cmd0CsHigh", 64'(cs_n_o), 64'(1));

    // CMD8 with long R7 response
    vb = validCount; tb = timeoutCount;
    applyStimulus(6'd8, 32'h0000_01AA, 1'b1, 1'b0);
    sendFrame(f);
    checkOutput("cmd8Frame", 64'(f), 64'h48_0000_01AA_87);
    checkOutput("cmd8Crc", 64'(f[7:0]), 64'h87);
    cardReply(8, 40'h01_0000_01AA, 40);
    repeat (2) @(negedge clk);
    checkOutput("cmd8Resp", 64'(cmdBus.resp_o), 64'h01_0000_01AA);
    checkOutput("cmd8ValidPulses", 64'(validCount - vb), 64'(1));
    checkOutput("cmd8NoTimeout", 64'(timeoutCount - tb), 64'(0));

    // CMD0 with silent card: timeout on the 64th rising edge in WAIT
    vb = validCount; tb = timeoutCount;
    applyStimulus(6'd0, 32'h0, 1'b0, 1'b0);
    sendFrame(f);
    checkOutput("toFrame", 64'(f), 64'h40_0000_0000_95);
    cardReply(63, 40'h0, 0);
    checkOutput("toNotYet", 64'(timeoutCount - tb), 64'(0));
    checkOutput("toCsStillLow", 64'(cs_n_o), 64'(0));
    cardReply(1, 40'h0, 0);
    repeat (2) @(negedge clk);
    checkOutput("toPulses", 64'(timeoutCount - tb), 64'(1));
    checkOutput("toNoValid", 64'(validCount - vb), 64'(0));
    checkOutput("toReadyBack", 64'(cmdBus.cmd_ready_o), 64'(1));
    checkOutput("toRespKept", 64'(cmdBus.resp_o), 64'h01_0000_01AA);

    // CMD55 with cmd_valid_i held through the transaction
    vb = validCount; ab = acceptCount;
    applyStimulus(6'd55, 32'h0, 1'b0, 1'b1);
    sendFrame(f);
    checkOutput("holdFrame", 64'(f), 64'h77_0000_0000_65);
    cardReply(8, {8'h01, 32'h0}, 7);
    checkOutput("holdOneAccept", 64'(acceptCount - ab), 64'(1));
    checkOutput("holdBusy", 64'(cmdBus.cmd_ready_o), 64'(0));
    cardReply(0, 40'h80_0000_0000, 1);
    repeat (2) @(negedge clk);
    cmdBus.cmd_valid_i = 1'b0;
    checkOutput("holdSecondAccept", 64'(acceptCount - ab), 64'(2));
    checkOutput("holdResp", 64'(cmdBus.resp_o), 64'h01_0000_0000);
    sendFrame(f);
    checkOutput("holdFrame2", 64'(f), 64'h77_0000_0000_65);
    cardReply(8, {8'h05, 32'h0}, 8);
    repeat (2) @(negedge clk);
    checkOutput("holdResp2", 64'(cmdBus.resp_o), 64'h05_0000_0000);
    checkOutput("holdAcceptTotal", 64'(acceptCount - ab), 64'(2));
    checkOutput("holdValidPulses", 64'(validCount - vb), 64'(2));

    // CMD41 abandoned by reset at bit 20, then resent at init speed
    vb = validCount; tb = timeoutCount;
    applyStimulus(6'd41, 32'h4000_0000, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) sclkCycle(1'b1, b);
    rst = 1'b0;
    #1;
    checkOutput("midRstMosi", 64'(mosi_o), 64'(1));
    checkOutput("midRstCsN", 64'(cs_n_o), 64'(1));
    checkOutput("midRstReady", 64'(cmdBus.cmd_ready_o), 64'(1));
    checkOutput("midRstResp", 64'(cmdBus.resp_o), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstNoValid", 64'(validCount - vb), 64'(0));
    checkOutput("midRstNoTimeout", 64'(timeoutCount - tb), 64'(0));
    gapClk = 61;
    applyStimulus(6'd41, 32'h4000_0000, 1'b0, 1'b0);
    sendFrame(f);
    checkOutput("slowCmd41Frame", 64'(f), 64'h69_4000_0000_77);
    cardReply(8, {8'h01, 32'h0}, 8);
    repeat (2) @(negedge clk);
    checkOutput("slowCmd41Resp", 64'(cmdBus.resp_o), 64'h01_0000_0000);

    // CMD8 again at init speed must match the fast-strobe result
    applyStimulus(6'd8, 32'h0000_01AA, 1'b1, 1'b0);
    sendFrame(f);
    checkOutput("slowCmd8Frame", 64'(f), 64'h48_0000_01AA_87);
    cardReply(8, 40'h01_0000_01AA, 40);
    repeat (2) @(negedge clk);
    checkOutput("slowCmd8Resp", 64'(cmdBus.resp_o), 64'h01_0000_01AA);
    checkOutput("slowValidPulses", 64'(validCount - vb), 64'(2));

    checkOutput("totalAccepts", 64'(acceptCount), 64'(8));
    checkOutput("totalValid", 64'(validCount), 64'(6));
    checkOutput("totalTimeouts", 64'(timeoutCount), 64'(1));
    checkOutput("csTracksBusy", 64'(csErrCount), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
